// File: rtl/rsa_xcel_mont_pkg.sv
// Shared types for the Montgomery-multiply step driver and its helpers.
package rsa_xcel_mont_pkg;

  // Driver FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // 33-bit Montgomery accumulator (one guard bit above the 32-bit modulus)
  typedef logic [32:0] acc_t;

  // Number of step transactions needed to consume a 32-bit x
  function automatic int unsigned niter(input int unsigned p_nsteps);
    return 32 / p_nsteps;
  endfunction

endpackage

// File: rtl/rsa_xcel_mont_CondSub.sv
// Final conditional subtract: reduces a 33-bit Montgomery accumulator that is
// known to be below 2n into the range [0, n).
module rsa_xcel_mont_CondSub
  import rsa_xcel_mont_pkg::*;
(
  input  acc_t        acc,
  input  logic [31:0] n,
  output logic [31:0] result
);

  acc_t diff;

  // Unsigned 33-bit compare against n, subtract once if acc >= n
  always_comb begin
    diff   = acc - {1'b0, n};
    result = (acc >= {1'b0, n}) ? diff[31:0] : acc[31:0];
  end

endmodule

// File: rtl/rsa_xcel_mont_step_driver.sv
// Iterative Montgomery-multiply controller. Feeds x to an external registered
// add-reduce step stage in p_nsteps-bit chunks (LSB first), loops the 33-bit
// accumulator back, and returns x*y*2^-32 mod n after a conditional subtract.
// Optional cycle counter output: define RSA_XCEL_MONT_STEP_DRIVER_PERF_EN.
module rsa_xcel_mont_step_driver
  import rsa_xcel_mont_pkg::*;
#(
  parameter int unsigned p_nsteps = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_val,
  output logic                req_rdy,
  input  logic [31:0]         req_x,
  input  logic [31:0]         req_y,
  input  logic [31:0]         req_n,
  output logic                resp_val,
  input  logic                resp_rdy,
  output logic [31:0]         resp_msg,
  output logic [p_nsteps-1:0] step_x_bits,
  output logic [31:0]         step_y,
  output logic [31:0]         step_n,
  output logic [32:0]         step_result_in,
  output logic                step_istream_val,
  input  logic                step_istream_rdy,
  input  logic [32:0]         step_result_out,
  input  logic                step_ostream_val,
  output logic                step_ostream_rdy
`ifdef RSA_XCEL_MONT_STEP_DRIVER_PERF_EN
  ,
  output logic [31:0]         perf_cycles
`endif
);

  localparam int unsigned NITER = niter(p_nsteps);
  localparam int unsigned IW    = (NITER > 1) ? $clog2(NITER) : 1;

  state_t        state, state_next;
  logic [IW-1:0] iter;
  acc_t          acc;
  logic [31:0]   x_reg, y_reg, n_reg;
  logic          accept;
  logic          last_iter;

  assign accept    = (state == IDLE) && req_val;
  assign last_iter = (iter == IW'(NITER - 1));

  assign step_x_bits    = x_reg[int'(iter) * p_nsteps +: p_nsteps];
  assign step_y         = y_reg;
  assign step_n         = n_reg;
  assign step_result_in = acc;

  rsa_xcel_mont_CondSub u_condsub (
    .acc    (acc),
    .n      (n_reg),
    .result (resp_msg)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Operand latch, iteration counter and accumulator loop-back
  always_ff @(posedge clk) begin
    if (reset) begin
      iter  <= '0;
      acc   <= '0;
      x_reg <= '0;
      y_reg <= '0;
      n_reg <= '0;
    end else if (accept) begin
      iter  <= '0;
      acc   <= '0;
      x_reg <= req_x;
      y_reg <= req_y;
      n_reg <= req_n;
    end else if (state == WAIT && step_ostream_val) begin
      acc <= step_result_out;
      if (!last_iter) iter <= iter + 1'b1;
    end
  end

  // Next-state and handshake outputs; reset forces the idle-side handshake
  always_comb begin
    state_next       = state;
    req_rdy          = 1'b0;
    resp_val         = 1'b0;
    step_istream_val = 1'b0;
    step_ostream_rdy = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) state_next = ISSUE;
      end
      ISSUE: begin
        step_istream_val = 1'b1;
        if (step_istream_rdy) state_next = WAIT;
      end
      WAIT: begin
        step_ostream_rdy = 1'b1;
        if (step_ostream_val) state_next = last_iter ? DONE : ISSUE;
      end
      DONE: begin
        resp_val = 1'b1;
        if (resp_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      req_rdy          = 1'b1;
      resp_val         = 1'b0;
      step_istream_val = 1'b0;
      step_ostream_rdy = 1'b0;
    end
  end

`ifdef RSA_XCEL_MONT_STEP_DRIVER_PERF_EN
  // Saturating count of cycles spent in ISSUE/WAIT for the current operation
  always_ff @(posedge clk) begin
    if (reset)
      perf_cycles <= '0;
    else if (accept)
      perf_cycles <= '0;
    else if ((state == ISSUE || state == WAIT) && perf_cycles != '1)
      perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rsa_xcel_mont_step_driver.sv
// Self-checking bench for rsa_xcel_mont_step_driver (p_nsteps = 8) with a
// behavioural step stage that can stall its input and delay its output.
module tb_rsa_xcel_mont_step_driver;

  localparam int unsigned P     = 8;
  localparam int unsigned NITER = 32 / P;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_val, req_rdy;
  logic [31:0]  req_x, req_y, req_n;
  logic         resp_val, resp_rdy;
  logic [31:0]  resp_msg;
  logic [P-1:0] step_x_bits;
  logic [31:0]  step_y, step_n;
  logic [32:0]  step_result_in, step_result_out;
  logic         step_istream_val, step_istream_rdy;
  logic         step_ostream_val, step_ostream_rdy;
`ifdef RSA_XCEL_MONT_STEP_DRIVER_PERF_EN
  logic [31:0]  perf_cycles;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rsa_xcel_mont_step_driver #(.p_nsteps(P)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_val          (req_val),
    .req_rdy          (req_rdy),
    .req_x            (req_x),
    .req_y            (req_y),
    .req_n            (req_n),
    .resp_val         (resp_val),
    .resp_rdy         (resp_rdy),
    .resp_msg         (resp_msg),
    .step_x_bits      (step_x_bits),
    .step_y           (step_y),
    .step_n           (step_n),
    .step_result_in   (step_result_in),
    .step_istream_val (step_istream_val),
    .step_istream_rdy (step_istream_rdy),
    .step_result_out  (step_result_out),
    .step_ostream_val (step_ostream_val),
    .step_ostream_rdy (step_ostream_rdy)
`ifdef RSA_XCEL_MONT_STEP_DRIVER_PERF_EN
    ,
    .perf_cycles      (perf_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: (x*y mod n) * 2^-32 mod n, halving modulo n 32 times
  function automatic logic [31:0] mont_ref(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] n);
    logic [63:0] r;
    r = (64'(x) * 64'(y)) % 64'(n);
    for (int i = 0; i < 32; i++) r = r[0] ? ((r + 64'(n)) >> 1) : (r >> 1);
    return r[31:0];
  endfunction

  // ---------------- behavioural step stage ----------------
  int          cfg_in = 0, cfg_out = 0;
  int          in_gap, out_gap;
  logic        st_busy;
  logic [32:0] st_res;

  function automatic logic [32:0] step_fn(input logic [P-1:0] xb, input logic [31:0] y,
                                          input logic [31:0] n, input logic [32:0] a);
    logic [34:0] t;
    t = {2'b00, a};
    for (int j = 0; j < int'(P); j++) begin
      if (xb[j]) t = t + 35'(y);
      if (t[0])  t = t + 35'(n);
      t = t >> 1;
    end
    return t[32:0];
  endfunction

  assign step_istream_rdy = !st_busy && (in_gap == 0);
  assign step_ostream_val = st_busy && (out_gap == 0);
  assign step_result_out  = st_res;

  always @(posedge clk) begin
    if (reset) begin
      st_busy <= 1'b0;
      in_gap  <= cfg_in;
      out_gap <= 0;
      st_res  <= '0;
    end else if (!st_busy) begin
      if (step_istream_val) begin
        if (in_gap == 0) begin
          st_busy <= 1'b1;
          st_res  <= step_fn(step_x_bits, step_y, step_n, step_result_in);
          out_gap <= cfg_out;
        end else in_gap <= in_gap - 1;
      end else in_gap <= cfg_in;
    end else begin
      if (out_gap != 0) out_gap <= out_gap - 1;
      else if (step_ostream_rdy) begin
        st_busy <= 1'b0;
        in_gap  <= cfg_in;
      end
    end
  end

  // Step inputs must hold while the request is stalled
  logic         hold_pend = 1'b0;
  logic [40:0]  prev_xr;
  logic [63:0]  prev_yn;
  always @(negedge clk) begin
    if (!reset && hold_pend && step_istream_val) begin
      check("stall_x_acc", 64'({step_x_bits, step_result_in}), 64'(prev_xr));
      check("stall_y_n", {step_y, step_n}, prev_yn);
    end
    hold_pend <= step_istream_val && !step_istream_rdy && !reset;
    prev_xr   <= {step_x_bits, step_result_in};
    prev_yn   <= {step_y, step_n};
  end

  // ---------------- transaction driver ----------------
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] n,
                        input int in_d, input int out_d, input int rs,
                        output logic [31:0] res, output int lat, output bit ok);
    int          w;
    int unsigned t0;
    logic [31:0] msg0;
    ok = 1'b0; res = '0; lat = 0;
    cfg_in = in_d; cfg_out = out_d;
    w = 0;
    while (!req_rdy && w < 50) begin @(negedge clk); w++; end
    if (!req_rdy) begin check("req_rdy_timeout", 0, 1); return; end
    req_val = 1'b1; req_x = x; req_y = y; req_n = n;
    t0 = cyc;
    @(posedge clk); #1;
    req_val = 1'b0;
    w = 0;
    @(negedge clk);
    while (!resp_val && w < 400) begin @(negedge clk); w++; end
    if (!resp_val) begin check("resp_timeout", 0, 1); return; end
    lat = int'(cyc - t0);
`ifdef RSA_XCEL_MONT_STEP_DRIVER_PERF_EN
    check("perf_cycles", 64'(perf_cycles), 64'(lat - 1));
`endif
    msg0 = resp_msg;
    // Offer a competing request during the stall; it must not be taken
    req_val = (rs > 0); req_x = ~x; req_y = 32'd1; req_n = 32'd3;
    for (int i = 0; i < rs; i++) begin
      @(negedge clk);
      check("stall_resp_val", 64'(resp_val), 1);
      check("stall_resp_msg", 64'(resp_msg), 64'(msg0));
      check("stall_req_rdy", 64'(req_rdy), 0);
    end
    res = resp_msg;
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    req_val  = 1'b0;
    @(negedge clk);
    check("idle_after_resp", {63'd0, req_rdy}, 1);
    check("no_resp_after", {63'd0, resp_val}, 0);
    ok = 1'b1;
  endtask

  task automatic op_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] n, input logic [31:0] exp,
                          input int in_d, input int out_d, input int rs);
    logic [31:0] res;
    int          lat;
    bit          ok;
    run_op(x, y, n, in_d, out_d, rs, res, lat, ok);
    if (ok) begin
      check({tag, "_msg"}, 64'(res), 64'(exp));
      check({tag, "_lat"}, 64'(lat), 64'(1 + NITER * (2 + in_d + out_d)));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] x, y, n;
    int          hs, k;
    bit          saw_resp;
    reset = 1'b1; req_val = 1'b0; resp_rdy = 1'b0;
    req_x = '0; req_y = '0; req_n = '0;
    @(negedge clk);
    check("rst_req_rdy", 64'(req_rdy), 1);
    check("rst_resp_val", 64'(resp_val), 0);
    check("rst_istream_val", 64'(step_istream_val), 0);
    check("rst_ostream_rdy", 64'(step_ostream_rdy), 0);
    @(negedge clk);
    check("rst_acc", 64'(step_result_in), 0);
    check("rst_yn", {step_y, step_n}, 0);
    reset = 1'b0;

    // Directed operands, no stalls
    op_check("d345", 32'd3, 32'd4, 32'd5, 32'd2, 0, 0, 0);
    op_check("d7815", 32'd7, 32'd8, 32'd15, 32'd11, 0, 0, 0);
    op_check("d161617", 32'd16, 32'd16, 32'd17, 32'd1, 0, 0, 0);
    op_check("dzero", 32'd0, 32'd12345, 32'd17, 32'd0, 0, 0, 0);

    // Step stalls plus response backpressure
    op_check("stall", 32'hDEADBEEF, 32'd1000, 32'd1009,
             mont_ref(32'hDEADBEEF, 32'd1000, 32'd1009), 3, 2, 5);

    // Reset in WAIT of iteration 2 aborts silently
    cfg_in = 0; cfg_out = 2;
    req_val = 1'b1; req_x = 32'h12345678; req_y = 32'd99; req_n = 32'd101;
    @(posedge clk); #1;
    req_val = 1'b0;
    hs = 0; k = 0;
    while (hs < 3 && k < 200) begin
      @(negedge clk);
      if (step_istream_val && step_istream_rdy) hs++;
      k++;
    end
    check("abort_handshakes", 64'(hs), 3);
    @(negedge clk);
    check("abort_in_wait", 64'(step_ostream_rdy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_req_rdy", 64'(req_rdy), 1);
    check("abort_istream", 64'(step_istream_val), 0);
    saw_resp = 1'b0;
    for (int i = 0; i < int'(2 * NITER + 10); i++) begin
      if (resp_val || step_istream_val) saw_resp = 1'b1;
      @(negedge clk);
    end
    check("abort_quiet", 64'(saw_resp), 0);
    op_check("post_abort", 32'd3, 32'd4, 32'd5, 32'd2, 0, 0, 0);

    // Randomized back-to-back operations
    for (int t = 0; t < 24; t++) begin
      n = ($urandom() & 32'h7fff_ffff) | 32'd1;
      if (n < 32'd3) n = 32'd3;
      x = $urandom();
      y = $urandom() % n;
      if (t % 6 == 0) x = 32'hFFFF_FFFF;
      if (t % 6 == 1) y = n - 32'd1;
      op_check("rand", x, y, n, mont_ref(x, y, n),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
